// File: rtl/pld_pkg.sv
// Shared definitions for the pld block and its fuse programmer: programmer
// state encoding and the fuse/word count helpers that size both designs.
package pld_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_AND,
      LOAD_OR,
      CHECK,
      COMMIT,
      ERROR
   } pld_prog_state_e;

   // AND-matrix fuses for an N-input pld: 2**(N+2) * N**2.
   function automatic int and_fuse_count(input int n);
      return (1 << (n + 2)) * n * n;
   endfunction

   // OR-matrix fuses for N inputs and M outputs: M * 2**(2N).
   function automatic int or_fuse_count(input int n, input int m);
      return m * (1 << (2 * n));
   endfunction

   // Number of W-bit words needed to carry the given number of bits.
   function automatic int word_count(input int bits, input int w);
      return (bits + w - 1) / w;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pld_cfg_checksum.sv
// Running XOR over bitstream words. Clear wins over enable so a new session
// can start accumulating on the very next accepted word.
module pld_cfg_checksum #(
   parameter int WORD_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear,
   input  logic              enable,
   input  logic [WORD_W-1:0] data,
   output logic [WORD_W-1:0] sum
);

   logic [WORD_W-1:0] sum_reg;

   // Accumulate accepted words; reset and clear both zero the sum.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear) begin
         sum_reg <= '0;
      end else if (enable) begin
         sum_reg <= sum_reg ^ data;
      end
   end

   assign sum = sum_reg;

endmodule

// File: rtl/pld_fuse_programmer.sv
// Fuse programmer for the pld block. Collects AND words, then OR words, then
// one checksum word over a valid/ready link into shadow registers, and only
// on a checksum match copies both shadows to the committed fuse outputs in
// a single edge, so the pld never sees a half-written configuration.
module pld_fuse_programmer
   import pld_pkg::*;
#(
   parameter int NUM_PORTS_IN  = 2,
   parameter int NUM_PORTS_OUT = 1,
   parameter int WORD_W        = 8
) (
   input  logic                                                clk_i,
   input  logic                                                rst_i,
   input  logic                                                start_i,
   input  logic                                                abort_i,
   input  logic [WORD_W-1:0]                                   cfg_data_i,
   input  logic                                                cfg_valid_i,
   output logic                                                cfg_ready_o,
   output logic [and_fuse_count(NUM_PORTS_IN)-1:0]             and_fuses_o,
   output logic [or_fuse_count(NUM_PORTS_IN, NUM_PORTS_OUT)-1:0] or_fuses_o,
   output logic                                                cfg_loaded_o,
   output logic                                                busy_o,
   output logic                                                done_o,
   output logic                                                error_o
);

   localparam int AF    = and_fuse_count(NUM_PORTS_IN);
   localparam int OF    = or_fuse_count(NUM_PORTS_IN, NUM_PORTS_OUT);
   localparam int AW    = word_count(AF, WORD_W);
   localparam int OW    = word_count(OF, WORD_W);
   localparam int CNT_W = $clog2(max2(AW, OW) + 1);

   localparam logic [CNT_W-1:0] AW_LAST = CNT_W'(AW - 1);
   localparam logic [CNT_W-1:0] OW_LAST = CNT_W'(OW - 1);

   pld_prog_state_e          state_reg, state_next;
   logic [CNT_W-1:0]         cnt_reg;
   logic [AW*WORD_W-1:0]     shadow_and_reg;
   logic [OW*WORD_W-1:0]     shadow_or_reg;
   logic [AF-1:0]            and_fuses_reg;
   logic [OF-1:0]            or_fuses_reg;
   logic                     loaded_reg;
   logic                     ready_reg;
   logic [WORD_W-1:0]        ck_sum;
   logic [AW-1:0]            and_we;
   logic [OW-1:0]            or_we;

   logic accept;
   logic start_go;
   logic shadow_clear;
   logic load_accept;
   logic commit_go;

   // abort_i masks the handshake even though ready may already be high.
   assign accept       = cfg_valid_i && ready_reg && !abort_i;
   assign start_go     = start_i && !abort_i && (state_reg == IDLE || state_reg == ERROR);
   assign shadow_clear = abort_i || start_go;
   assign load_accept  = accept && (state_reg == LOAD_AND || state_reg == LOAD_OR);
   assign commit_go    = accept && (state_reg == CHECK) && (cfg_data_i == ck_sum);

   // One write enable per shadow word, selected by the word counter.
   genvar gi;
   generate
      for (gi = 0; gi < AW; gi++) begin : g_and_we
         assign and_we[gi] = accept && (state_reg == LOAD_AND) && (cnt_reg == CNT_W'(gi));
      end
      for (gi = 0; gi < OW; gi++) begin : g_or_we
         assign or_we[gi] = accept && (state_reg == LOAD_OR) && (cnt_reg == CNT_W'(gi));
      end
   endgenerate

   pld_cfg_checksum #(
      .WORD_W (WORD_W)
   ) u_checksum (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear  (shadow_clear),
      .enable (load_accept),
      .data   (cfg_data_i),
      .sum    (ck_sum)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (start_go) state_next = LOAD_AND;
         LOAD_AND: if (accept && cnt_reg == AW_LAST) state_next = LOAD_OR;
         LOAD_OR:  if (accept && cnt_reg == OW_LAST) state_next = CHECK;
         CHECK:    if (accept) state_next = commit_go ? COMMIT : ERROR;
         COMMIT:   state_next = IDLE;
         ERROR:    if (start_go) state_next = LOAD_AND;
         default:  state_next = IDLE;
      endcase
      if (abort_i) begin
         state_next = IDLE;
      end
   end

   // Word counter restarts on every state change, counts accepted load words.
   always_ff @(posedge clk_i) begin
      if (rst_i || state_next != state_reg) begin
         cnt_reg <= '0;
      end else if (load_accept) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   // Shadow registers: cleared at session start/abort, filled word by word.
   always_ff @(posedge clk_i) begin
      if (rst_i || shadow_clear) begin
         shadow_and_reg <= '0;
         shadow_or_reg  <= '0;
      end else begin
         for (int k = 0; k < AW; k++) begin
            if (and_we[k]) shadow_and_reg[k*WORD_W +: WORD_W] <= cfg_data_i;
         end
         for (int k = 0; k < OW; k++) begin
            if (or_we[k]) shadow_or_reg[k*WORD_W +: WORD_W] <= cfg_data_i;
         end
      end
   end

   // Atomic commit on the checksum handshake edge, so the new vectors appear
   // in the same cycle as done_o. Padding bits of the last word are dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         and_fuses_reg <= '0;
         or_fuses_reg  <= '0;
         loaded_reg    <= 1'b0;
      end else if (commit_go) begin
         and_fuses_reg <= shadow_and_reg[AF-1:0];
         or_fuses_reg  <= shadow_or_reg[OF-1:0];
         loaded_reg    <= 1'b1;
      end
   end

   // Ready is registered from the next state, independent of cfg_valid_i.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready_reg <= 1'b0;
      end else begin
         ready_reg <= (state_next == LOAD_AND) || (state_next == LOAD_OR) ||
                      (state_next == CHECK);
      end
   end

   assign cfg_ready_o  = ready_reg;
   assign and_fuses_o  = and_fuses_reg;
   assign or_fuses_o   = or_fuses_reg;
   assign cfg_loaded_o = loaded_reg;
   assign busy_o       = (state_reg == LOAD_AND) || (state_reg == LOAD_OR) ||
                         (state_reg == CHECK) || (state_reg == COMMIT);
   assign done_o       = (state_reg == COMMIT);
   assign error_o      = (state_reg == ERROR);

endmodule

// File: tb/tb_pld_fuse_programmer.sv
// Bench for pld_fuse_programmer (N=2, M=1, WORD_W=8: 8 AND words, 2 OR words).
// Sessions come from a vector table; expected commit/error outcomes go into a
// scoreboard queue when the checksum word is driven and are popped when the
// DUT answers one cycle after the checksum handshake.
module tb_pld_fuse_programmer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [7:0]  cfg_data;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [63:0] and_fuses;
   logic [15:0] or_fuses;
   logic        cfg_loaded;
   logic        busy;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;

   // Committed-configuration model.
   logic [63:0] model_and    = '0;
   logic [15:0] model_or     = '0;
   logic        model_loaded = 1'b0;

   typedef struct {
      logic [63:0] and_v;
      logic [15:0] or_v;
      logic [7:0]  ck_flip;
      bit          gaps;
   } vec_t;

   typedef struct {
      bit          ok;
      logic [63:0] and_v;
      logic [15:0] or_v;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[6];

   always #5 clk = ~clk;

   pld_fuse_programmer #(
      .NUM_PORTS_IN  (2),
      .NUM_PORTS_OUT (1),
      .WORD_W        (8)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .cfg_data_i   (cfg_data),
      .cfg_valid_i  (cfg_valid),
      .cfg_ready_o  (cfg_ready),
      .and_fuses_o  (and_fuses),
      .or_fuses_o   (or_fuses),
      .cfg_loaded_o (cfg_loaded),
      .busy_o       (busy),
      .done_o       (done),
      .error_o      (error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_committed();
      check("and_fuses", and_fuses, model_and);
      check("or_fuses", 64'(or_fuses), 64'(model_or));
      check("cfg_loaded", 64'(cfg_loaded), 64'(model_loaded));
   endtask

   // Offer one word until it is accepted; optional random 50% valid gaps.
   task automatic send_word(input logic [7:0] w, input bit gaps);
      bit hs = 1'b0;
      int guard = 0;
      while (!hs && guard < 200) begin
         @(negedge clk);
         cfg_data  = w;
         cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         hs        = cfg_valid && cfg_ready;
         guard++;
         @(posedge clk);
      end
      if (!hs) begin
         n_checks++;
         n_fail++;
         $display("FAIL handshake_timeout: word %h not accepted, limit 200 cycles", w);
      end
   endtask

   task automatic start_session();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      check("error_after_start", 64'(error), 64'd0);
   endtask

   task automatic run_session(input vec_t v, input int id);
      logic [7:0] ck = '0;
      logic [7:0] w;
      exp_t       e;
      start_session();
      for (int k = 0; k < 8; k++) begin
         w  = v.and_v[k*8 +: 8];
         ck = ck ^ w;
         send_word(w, v.gaps);
      end
      for (int k = 0; k < 2; k++) begin
         w  = v.or_v[k*8 +: 8];
         ck = ck ^ w;
         send_word(w, v.gaps);
      end
      ck      = ck ^ v.ck_flip;
      e.ok    = (v.ck_flip == 8'h00);
      e.and_v = v.and_v;
      e.or_v  = v.or_v;
      sb_q.push_back(e);
      send_word(ck, v.gaps);
      // One cycle after the checksum handshake.
      @(negedge clk);
      cfg_valid = 1'b0;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_empty: session %0d has no expectation", id);
         return;
      end
      e = sb_q.pop_front();
      if (e.ok) begin
         model_and    = e.and_v;
         model_or     = e.or_v;
         model_loaded = 1'b1;
         check("done_latency", 64'(done), 64'd1);
      end else begin
         check("error_on_bad_checksum", 64'(error), 64'd1);
         check("no_done_on_error", 64'(done), 64'd0);
      end
      check("ready_low_after_check", 64'(cfg_ready), 64'd0);
      check_committed();
      if (!e.ok) begin
         repeat (3) begin
            @(negedge clk);
            check("done_stays_low", 64'(done), 64'd0);
            check("error_held", 64'(error), 64'd1);
         end
      end
      $display("session %0d: and=%h or=%h ck=%h gaps=%0d expect_ok=%0d loaded=%0d",
               id, v.and_v, v.or_v, ck, v.gaps, e.ok, cfg_loaded);
   endtask

   initial begin
      vec_t v;
      tbl[0] = '{64'h0807060504030201, 16'h5AA5, 8'h00, 1'b0};
      tbl[1] = '{64'h0807060504030201, 16'h5AA5, 8'h01, 1'b0};
      tbl[2] = '{64'hDEADBEEF01234567, 16'h1234, 8'h00, 1'b1};
      tbl[3] = '{64'hFFFF0000AAAA5555, 16'hFFFF, 8'h80, 1'b1};
      tbl[4] = '{64'h0000000000000000, 16'h0000, 8'h00, 1'b0};
      tbl[5] = '{{$urandom, $urandom}, 16'($urandom), 8'h00, 1'b1};

      rst = 1'b1; start = 1'b0; abort = 1'b0; cfg_data = '0; cfg_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_ready", 64'(cfg_ready), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_error", 64'(error), 64'd0);
      check_committed();
      $display("reset: outputs idle");

      for (int i = 0; i < 6; i++) begin
         run_session(tbl[i], i);
      end

      // Abort after four AND words; the word offered with abort is dropped.
      v = '{64'h1122334455667788, 16'hC33C, 8'h00, 1'b0};
      start_session();
      for (int k = 0; k < 4; k++) send_word(8'hE0 + 8'(k), 1'b0);
      @(negedge clk);
      abort = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h77;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0; cfg_valid = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(cfg_ready), 64'd0);
      check("abort_error", 64'(error), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check_committed();
      $display("abort: returned to idle, committed config kept");
      run_session(v, 6);

      // Reset while loading OR words wipes the committed configuration.
      start_session();
      for (int k = 0; k < 8; k++) send_word(8'h30 + 8'(k), 1'b0);
      send_word(8'h99, 1'b0);
      @(negedge clk);
      rst = 1'b1; cfg_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_and = '0; model_or = '0; model_loaded = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_ready", 64'(cfg_ready), 64'd0);
      check("midrst_error", 64'(error), 64'd0);
      check_committed();
      $display("reset during LOAD_OR: configuration cleared");

      v = '{64'h0F1E2D3C4B5A6978, 16'h8001, 8'h00, 1'b1};
      run_session(v, 7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
